// File: rtl/avr_fetch_unit.sv
// Instruction fetch stage: streams words from synchronous program memory into a
// two-entry buffer, assembles one/two-word AVR instructions and shares the port with LPM.
module avr_fetch_unit (
  input  logic        clk,
  input  logic        rst,
  output logic [13:0] pmem_addr,
  input  logic [15:0] pmem_dout,
  output logic [15:0] ir,
  output logic [15:0] ir_ext,
  output logic [13:0] ir_pc,
  output logic        ir_two,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect,
  input  logic [13:0] redirect_pc,
  input  logic        lpm_req,
  input  logic [13:0] lpm_addr,
  output logic [15:0] lpm_data,
  output logic        lpm_done
);

  typedef enum logic [1:0] {L_IDLE, L_ADDR, L_DATA, L_DONE} lpm_state_e;

  lpm_state_e  lst_q, lst_d;
  logic [13:0] fa_q, fa_d;
  logic [13:0] a0_q, a0_d, a1_q, a1_d;
  logic [15:0] w0_q, w0_d, w1_q, w1_d;
  logic [13:0] infl_addr_q, infl_addr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        infl_q, infl_d;
  logic [15:0] lpm_data_q;

  logic [1:0]  pop;
  logic [1:0]  rem;
  logic [2:0]  occ;
  logic        head_two;
  logic        issue;
  logic        lpm_port;
  logic        lpm_capture;

  // LDS/STS (1001 00xd dddd 0000 / 1001 001r rrrr 0000) and JMP/CALL (1001 010k kkkk 11xk)
  function automatic logic is_two_word(input logic [15:0] w);
    return ((w & 16'hFE0F) == 16'h9000) ||
           ((w & 16'hFE0F) == 16'h9200) ||
           ((w & 16'hFE0C) == 16'h940C);
  endfunction

  assign head_two = (cnt_q != 2'd0) && is_two_word(w0_q);
  assign ir_valid = (cnt_q != 2'd0) && (!head_two || (cnt_q == 2'd2));
  assign pop      = (ir_valid && ir_ready) ? (head_two ? 2'd2 : 2'd1) : 2'd0;
  assign rem      = cnt_q - pop;
  assign occ      = {1'b0, cnt_q} + {2'b00, infl_q} - {1'b0, pop};
  // Only issue when the word it returns is guaranteed a free slot
  assign issue    = !redirect && !lpm_port && (occ <= 3'd1);

  assign ir       = w0_q;
  assign ir_ext   = w1_q;
  assign ir_pc    = a0_q;
  assign ir_two   = head_two;
  assign lpm_data = lpm_data_q;

  always_comb begin
    if (redirect)      pmem_addr = redirect_pc;
    else if (lpm_port) pmem_addr = lpm_addr;
    else               pmem_addr = fa_q;
  end

  always_comb begin
    w0_d        = w0_q;
    a0_d        = a0_q;
    w1_d        = w1_q;
    a1_d        = a1_q;
    cnt_d       = cnt_q;
    infl_d      = infl_q;
    infl_addr_d = infl_addr_q;
    fa_d        = fa_q;
    if (redirect) begin
      cnt_d       = 2'd0;
      infl_d      = 1'b1;
      infl_addr_d = redirect_pc;
      fa_d        = redirect_pc + 14'd1;
    end else begin
      if (pop == 2'd1) begin
        w0_d = w1_q;
        a0_d = a1_q;
      end
      if (infl_q) begin
        if (rem == 2'd0) begin
          w0_d = pmem_dout;
          a0_d = infl_addr_q;
        end else begin
          w1_d = pmem_dout;
          a1_d = infl_addr_q;
        end
      end
      cnt_d  = occ[1:0];
      infl_d = issue;
      if (issue) begin
        infl_addr_d = fa_q;
        fa_d        = fa_q + 14'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fa_q        <= '0;
      w0_q        <= '0;
      a0_q        <= '0;
      w1_q        <= '0;
      a1_q        <= '0;
      cnt_q       <= '0;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
    end else begin
      fa_q        <= fa_d;
      w0_q        <= w0_d;
      a0_q        <= a0_d;
      w1_q        <= w1_d;
      a1_q        <= a1_d;
      cnt_q       <= cnt_d;
      infl_q      <= infl_d;
      infl_addr_q <= infl_addr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lst_q <= L_IDLE;
    else     lst_q <= lst_d;
  end

  // A redirect steals the port from L_ADDR, so the LPM read is retried next cycle
  always_comb begin
    lst_d = lst_q;
    case (lst_q)
      L_IDLE:  if (lpm_req) lst_d = L_ADDR;
      L_ADDR:  if (!redirect) lst_d = L_DATA;
      L_DATA:  lst_d = L_DONE;
      L_DONE:  lst_d = L_IDLE;
      default: lst_d = L_IDLE;
    endcase
  end

  always_comb begin
    lpm_port    = (lst_q == L_ADDR);
    lpm_capture = (lst_q == L_DATA);
    lpm_done    = (lst_q == L_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              lpm_data_q <= '0;
    else if (lpm_capture) lpm_data_q <= pmem_dout;
  end

endmodule

// File: tb/tb_avr_fetch_unit.sv
// Directed bench for avr_fetch_unit with a synchronous 16K x 16 program memory model.
module tb_avr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] pmem_addr;
  logic [15:0] pmem_dout = 16'h0000;
  logic [15:0] ir, ir_ext;
  logic [13:0] ir_pc;
  logic        ir_two, ir_valid, ir_ready;
  logic        redirect;
  logic [13:0] redirect_pc;
  logic        lpm_req;
  logic [13:0] lpm_addr;
  logic [15:0] lpm_data;
  logic        lpm_done;

  logic [15:0] mem [0:16383];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) pmem_dout <= mem[pmem_addr];

  avr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pmem_addr   (pmem_addr),
    .pmem_dout   (pmem_dout),
    .ir          (ir),
    .ir_ext      (ir_ext),
    .ir_pc       (ir_pc),
    .ir_two      (ir_two),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .lpm_req     (lpm_req),
    .lpm_addr    (lpm_addr),
    .lpm_data    (lpm_data),
    .lpm_done    (lpm_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 16'h1000 | {4'h0, i[11:0]};
    for (int i = 0; i < 4; i++) mem[i] = 16'h0000;
    mem[14'h0200] = 16'hBEEF;

    rst = 1'b1; ir_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    lpm_req = 1'b0; lpm_addr = '0;
    #1;
    check("rst_pmem_addr", pmem_addr, 0);
    check("rst_ir_valid", ir_valid, 0);
    check("rst_ir_two", ir_two, 0);
    check("rst_ir", ir, 0);
    check("rst_ir_ext", ir_ext, 0);
    check("rst_ir_pc", ir_pc, 0);
    check("rst_lpm_data", lpm_data, 0);
    check("rst_lpm_done", lpm_done, 0);

    // NOP stream from reset
    cyc(); cyc(); rst = 1'b0; #1;
    check("c0_addr", pmem_addr, 0);
    check("c0_valid", ir_valid, 0);
    cyc(); #1;
    check("c1_addr", pmem_addr, 1);
    check("c1_valid", ir_valid, 0);
    for (int k = 0; k < 6; k++) begin
      cyc(); #1;
      check("stream_valid", ir_valid, 1);
      check("stream_pc", ir_pc, k);
      check("stream_ir", ir, (k < 4) ? 32'h0 : (32'h1000 | k));
    end

    // decoder stall: head holds, no new issue
    for (int s = 0; s < 5; s++) begin
      cyc(); ir_ready = 1'b0; #1;
      check("stall_valid", ir_valid, 1);
      check("stall_pc", ir_pc, 6);
      check("stall_addr", pmem_addr, 8);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(); ir_ready = 1'b1; #1;
      check("resume_valid", ir_valid, 1);
      check("resume_pc", ir_pc, 6 + k);
    end

    // JMP at 0
    mem[0] = 16'h940C; mem[1] = 16'h0010; mem[2] = 16'h0000; mem[3] = 16'h0000;
    rst = 1'b1;
    cyc(); cyc(); rst = 1'b0; #1;
    cyc(); #1;
    cyc(); #1;
    check("jmp_c2_valid", ir_valid, 0);
    cyc(); #1;
    check("jmp_valid", ir_valid, 1);
    check("jmp_two", ir_two, 1);
    check("jmp_ir", ir, 16'h940C);
    check("jmp_ext", ir_ext, 16'h0010);
    check("jmp_pc", ir_pc, 0);
    cyc(); #1;
    check("jmp_bubble", ir_valid, 0);
    cyc(); #1;
    check("after_jmp_valid", ir_valid, 1);
    check("after_jmp_pc", ir_pc, 2);
    check("after_jmp_two", ir_two, 0);

    // fill buffer, then redirect
    for (int s = 0; s < 3; s++) begin
      cyc(); ir_ready = 1'b0; #1;
    end
    cyc(); redirect = 1'b1; redirect_pc = 14'h0100; #1;
    check("redir_addr", pmem_addr, 14'h0100);
    cyc(); redirect = 1'b0; ir_ready = 1'b1; #1;
    check("redir_flush", ir_valid, 0);
    cyc(); #1;
    check("redir_valid", ir_valid, 1);
    check("redir_pc", ir_pc, 14'h0100);
    check("redir_ir", ir, 16'h1100);

    // LPM during streaming
    cyc(); lpm_req = 1'b1; lpm_addr = 14'h0200; #1;
    check("lpm_a_pc", ir_pc, 14'h0101);
    check("lpm_a_done", lpm_done, 0);
    cyc(); #1;
    check("lpm_addr_port", pmem_addr, 14'h0200);
    check("lpm_a1_pc", ir_pc, 14'h0102);
    cyc(); #1;
    check("lpm_a2_pc", ir_pc, 14'h0103);
    check("lpm_a2_done", lpm_done, 0);
    cyc(); lpm_req = 1'b0; #1;
    check("lpm_done", lpm_done, 1);
    check("lpm_data", lpm_data, 16'hBEEF);
    check("lpm_bubble", ir_valid, 0);
    cyc(); #1;
    check("lpm_after_done", lpm_done, 0);
    check("lpm_after_valid", ir_valid, 1);
    check("lpm_after_pc", ir_pc, 14'h0104);

    // STS at top of memory, operand wraps to 0
    mem[0] = 16'h0123; mem[14'h3FFF] = 16'h9000;
    cyc(); redirect = 1'b1; redirect_pc = 14'h3FFF; #1;
    check("wrap_redir_addr", pmem_addr, 14'h3FFF);
    cyc(); redirect = 1'b0; #1;
    check("wrap_fa", pmem_addr, 0);
    check("wrap_w1_valid", ir_valid, 0);
    cyc(); #1;
    check("wrap_w2_valid", ir_valid, 0);
    cyc(); #1;
    check("sts_valid", ir_valid, 1);
    check("sts_two", ir_two, 1);
    check("sts_ir", ir, 16'h9000);
    check("sts_ext", ir_ext, 16'h0123);
    check("sts_pc", ir_pc, 14'h3FFF);
    cyc(); #1;
    check("sts_bubble", ir_valid, 0);
    cyc(); #1;
    check("after_sts_pc", ir_pc, 1);
    check("after_sts_ir", ir, 16'h0010);

    // reset while LPM owns the port
    cyc(); lpm_req = 1'b1; lpm_addr = 14'h0200; #1;
    cyc(); #1;
    check("rlpm_port", pmem_addr, 14'h0200);
    rst = 1'b1; lpm_req = 1'b0; #1;
    check("rlpm_addr", pmem_addr, 0);
    check("rlpm_valid", ir_valid, 0);
    check("rlpm_data", lpm_data, 0);
    check("rlpm_done", lpm_done, 0);
    cyc(); cyc(); rst = 1'b0; #1;
    check("rlpm_c0_addr", pmem_addr, 0);
    cyc(); #1;
    check("rlpm_c1_done", lpm_done, 0);
    cyc(); #1;
    check("rlpm_c2_valid", ir_valid, 1);
    check("rlpm_c2_ir", ir, 16'h0123);
    check("rlpm_c2_done", lpm_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
